namco_video_timing: RTL

Raster timing generator for the Namco Galaga-hardware cores (Dig Dug and siblings). It runs from the 48 MHz master clock and derives the 6 MHz pixel clock. It produces the pixel/line position counters, blanking and sync signals consumed by the game core (PH/PV/PCLK inputs) and by the video output / scan-doubler stage. All outputs are registered, and every output changes only on MCLK rising edges.

---
 rtl/namco_video_timing_if.sv | 14 +
 rtl/namco_video_timing.sv | 73 +++++++
 2 files changed

// File: rtl/namco_video_timing_if.sv
// namco_video_timing_if: raster timing bundle from the timing generator to the game core and video stage
interface namco_video_timing_if;
   logic       PCLK;
   logic       PCLK_EN;
   logic [8:0] HPOS;
   logic [8:0] VPOS;
   logic       HBLK;
   logic       VBLK;
   logic       HSYN;
   logic       VSYN;
   logic       FRAME;
   modport master (output PCLK, PCLK_EN, HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, FRAME);
   modport slave  (input  PCLK, PCLK_EN, HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, FRAME);
endinterface

// File: rtl/namco_video_timing.sv
// namco_video_timing: pixel clock divider, H/V position counters, blank/sync decode and frame strobe
module namco_video_timing #(
   parameter int CLK_DIV  = 8,
   parameter int H_TOTAL  = 384,
   parameter int H_ACTIVE = 288,
   parameter int HS_START = 304,
   parameter int HS_LEN   = 32,
   parameter int V_TOTAL  = 264,
   parameter int V_ACTIVE = 224,
   parameter int VS_START = 240,
   parameter int VS_LEN   = 8
) (
   input  logic MCLK,
   input  logic RESET,
   namco_video_timing_if.master vt
);
   localparam int DW = $clog2(CLK_DIV);
   logic [DW-1:0] div_q, div_d;
   logic [8:0]    hpos_q, hpos_d, vpos_q, vpos_d;
   logic          pclk_q, pclk_d, en_q, en_d, hblk_q, hblk_d, vblk_q, vblk_d;
   logic          hsyn_q, hsyn_d, vsyn_q, vsyn_d, frame_q, frame_d;
   logic          pix_wrap, line_wrap, frame_wrap;
   // Decodes look at next-state counters so they flip on the same edge as HPOS/VPOS
   always_comb begin
      pix_wrap   = div_q == DW'(CLK_DIV - 1);
      line_wrap  = pix_wrap && hpos_q == 9'(H_TOTAL - 1);
      frame_wrap = line_wrap && vpos_q == 9'(V_TOTAL - 1);
      div_d      = pix_wrap ? '0 : div_q + 1'b1;
      hpos_d     = line_wrap ? '0 : hpos_q + 9'(pix_wrap);
      vpos_d     = frame_wrap ? '0 : vpos_q + 9'(line_wrap);
      pclk_d     = div_d >= DW'(CLK_DIV / 2);
      en_d       = div_d == DW'(CLK_DIV - 1);
      hblk_d     = {1'b0, hpos_d} >= 10'(H_ACTIVE);
      vblk_d     = {1'b0, vpos_d} >= 10'(V_ACTIVE);
      hsyn_d     = !({1'b0, hpos_d} >= 10'(HS_START) && {1'b0, hpos_d} < 10'(HS_START + HS_LEN));
      vsyn_d     = !({1'b0, vpos_d} >= 10'(VS_START) && {1'b0, vpos_d} < 10'(VS_START + VS_LEN));
      frame_d    = frame_wrap;
   end
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         div_q   <= '0;
         hpos_q  <= '0;
         vpos_q  <= '0;
         pclk_q  <= 1'b0;
         en_q    <= 1'b0;
         hblk_q  <= 1'b0;
         vblk_q  <= 1'b0;
         hsyn_q  <= 1'b1;
         vsyn_q  <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         pclk_q  <= pclk_d;
         en_q    <= en_d;
         hblk_q  <= hblk_d;
         vblk_q  <= vblk_d;
         hsyn_q  <= hsyn_d;
         vsyn_q  <= vsyn_d;
         frame_q <= frame_d;
      end
   end
   assign vt.PCLK    = pclk_q;
   assign vt.PCLK_EN = en_q;
   assign vt.HPOS    = hpos_q;
   assign vt.VPOS    = vpos_q;
   assign vt.HBLK    = hblk_q;
   assign vt.VBLK    = vblk_q;
   assign vt.HSYN    = hsyn_q;
   assign vt.VSYN    = vsyn_q;
   assign vt.FRAME   = frame_q;
endmodule
